// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives a 1-cycle-latency ROM, presents PC/instr to IF/ID.
// A one-entry hold buffer keeps the visible instruction stable across stalls.
module if_fetch_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  output logic        imem_en,
  output logic [7:0]  imem_addr,
  input  logic [19:0] imem_rdata,
  output logic [7:0]  pc_out,
  output logic [19:0] instr_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  fpc_q, fpc_d;
  logic [7:0]  opc_q, opc_d;
  logic [19:0] hold_q, hold_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BOOT;
      fpc_q   <= 8'h00;
      opc_q   <= 8'h00;
      hold_q  <= 20'h0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      opc_q   <= opc_d;
      hold_q  <= hold_d;
    end
  end

  // Every enabled ROM read is a fetch; branch overrides stall.
  always_comb begin
    imem_addr = branch_taken ? branch_target : fpc_q;
    imem_en   = branch_taken | ~stall;
    fpc_d     = fpc_q;
    opc_d     = opc_q;
    hold_d    = hold_q;
    if (imem_en) begin
      opc_d = imem_addr;
      fpc_d = imem_addr + 8'd1;
    end
    if (branch_taken)
      hold_d = 20'h0;
    else if (state_q == RUN && stall)
      hold_d = imem_rdata;
  end

  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT:    state_d = stall ? BOOT : RUN;
        RUN:     state_d = stall ? HOLD : RUN;
        HOLD:    state_d = stall ? HOLD : RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    pc_out    = opc_q;
    instr_out = 20'h0;
    valid_out = 1'b0;
    if (!branch_taken) begin
      case (state_q)
        RUN: begin
          instr_out = imem_rdata;
          valid_out = 1'b1;
        end
        HOLD: begin
          instr_out = hold_q;
          valid_out = 1'b1;
        end
        default: begin
          instr_out = 20'h0;
          valid_out = 1'b0;
        end
      endcase
    end
  end

endmodule
